fetch_instr_queue: RTL and testbench
====================================

// Module: fetch_instr_queue
// PURPOSE
//  Decoupling instruction queue between the fetch-buffer word select (ReadDataWord/PCF) and the decode stage.
//  - Captures one aligned fetched instruction per cycle with its PC. Tags it compressed when instr[1:0] != 2'b11.
//  - Presents instructions to decode in order, using a valid/ready handshake.
//  - Absorbs decode stalls, so fetch keeps streaming cache lines while decode is stalled.
// PARAMETERS
//  XLEN   64  PC width (taken from P.XLEN)
//  ILEN   32  instruction width
//  DEPTH  4   number of entries; power of 2, >= 2
//  NOP    32'h00000013  value driven on deq_instr when the queue is empty
// PORTS
//  clk             in   1           clock
//  reset           in   1           synchronous, active-high
//  FlushD          in   1           flush: discard all entries (branch mispredict / trap)
//  enq_valid       in   1           fetch offers an instruction
//  enq_ready       out  1           queue can accept; registered, = (count < DEPTH)
//  enq_instr       in   ILEN        raw fetched word (low half only is meaningful if compressed)
//  enq_pc          in   XLEN        PC of enq_instr
//  deq_valid       out  1           head entry valid
//  deq_ready       in   1           decode consumes head
//  deq_instr       out  ILEN        head instruction; upper 16 bits zeroed if compressed
//  deq_pc          out  XLEN        head PC
//  deq_compressed  out  1           head is a 16-bit instruction
//  count           out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset values: count=0, deq_valid=0, enq_ready=1, deq_instr=NOP, deq_pc=0, deq_compressed=0. Both pointers = 0.
//  - Enqueue fires on enq_valid & enq_ready. The entry is written at wr_ptr, and wr_ptr = (wr_ptr+1) mod DEPTH.
//  - Dequeue fires on deq_valid & deq_ready. rd_ptr = (rd_ptr+1) mod DEPTH.
//  - Compressed detection and zeroing of instr[31:16] happen at enqueue and are stored with the entry.
//  - Occupancy state, derived from count: EMPTY (0), PARTIAL, FULL (DEPTH).
//    - EMPTY->PARTIAL on enqueue only.
//    - PARTIAL->FULL when an enqueue without dequeue brings count to DEPTH.
//    - FULL->PARTIAL on dequeue.
//    - PARTIAL->EMPTY when a dequeue without enqueue brings count to 0.
//  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
//    - When FULL, enq_ready=0, so no enqueue happens even if deq_ready=1. No same-cycle pass-through on full.
//  - Latency: enqueue to deq_valid is 1 cycle. Order is strictly FIFO.
//  - enq_ready depends only on registered count, never combinationally on deq_ready.
//  - FlushD=1 at a clock edge clears the queue exactly as reset does.
//    - Flush takes precedence over a simultaneous enqueue or dequeue; both are dropped.
//    - Outputs in the flush cycle itself remain those of the pre-flush state. Decode ignores them under FlushD.
//  - Reset or flush during any state returns to EMPTY with no residual entries.
//  - deq_instr/deq_pc/deq_compressed are taken from the entry at rd_ptr when deq_valid=1; otherwise NOP/0/0.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. FULL/EMPTY are resolved by count, not by pointer compare.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//    - When count==0 and enq_valid=1, deq_valid=1 combinationally and deq_* show the enqueued data (after compress zeroing).
//    - If deq_ready=1 in that same cycle, the entry is consumed and not written; count stays 0. Latency is 0 cycles.
//  IFQ_BYPASS_EN undefined:
//    - deq_* depend only on registered state. Minimum latency is 1 cycle; no enq->deq combinational path.
// STRUCTURE
//  - Shared package cvw: typedef struct packed {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr; logic compressed;} ifq_entry_t.
//    The NOP instruction constant also lives there.
//  - Sub-module: ifq_storage, a DEPTH x ifq_entry_t register array.
//    - One write port (we, waddr) and one async read port (raddr).
//    - No reset on data; validity is tracked by count.
// TESTING
//  1. Reset, then enq 0x00000013 @pc 0x80000000
//     -> next cycle deq_valid=1, deq_pc=0x80000000, deq_compressed=0.
//  2. Enq 0x00004501 (c.li) @pc 0x80000004
//     -> deq_instr=0x00004501, deq_compressed=1. Enq 0xABCD4501 -> deq_instr=0x00004501.
//  3. Hold deq_ready=0 and offer 6 instrs
//     -> accepts 4, enq_ready=0 at count=4. Release -> dequeue order pc0..pc3, no duplicates or losses.
//  4. count=2, enq and deq both fire for 8 cycles
//     -> count stays 2. Pointers wrap past DEPTH with order preserved.
//  5. count=3, FlushD=1 with enq_valid=1 and deq_ready=1
//     -> next cycle count=0, deq_valid=0, deq_instr=0x00000013, enq_ready=1.
//  6. IFQ_BYPASS_EN, empty, enq 0x00000093 with deq_ready=1
//     -> same-cycle deq_valid=1 and count stays 0. Without the macro, deq_valid=0 that cycle.

Source files
------------

// File: rtl/cvw_pkg.sv
// Shared fetch-side types: the instruction queue entry, the NOP constant and the capture helper.
package cvw;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            compressed;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } ifq_occ_e;

  // Compressed encodings only define the low half; the upper half is cleared once, at capture.
  function automatic ifq_entry_t ifq_capture(input logic [ILEN-1:0] instr,
                                             input logic [XLEN-1:0] pc);
    ifq_entry_t e;
    e.pc         = pc;
    e.compressed = (instr[1:0] != 2'b11);
    e.instr      = e.compressed ? {16'h0000, instr[15:0]} : instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_instr_queue_storage.sv
// Entry storage for the fetch instruction queue: one write port, one asynchronous read port.
// Data is never reset; which entries are live is known only from the queue occupancy.
module ifq_storage
  import cvw::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  ifq_entry_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output ifq_entry_t                 rdata
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_instr_queue.sv
// Decoupling queue between fetch word select and decode, with valid/ready on both sides.
// Optional macro IFQ_BYPASS_EN adds a zero-latency empty-queue path from enq_* to deq_*.
module fetch_instr_queue
  import cvw::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          FlushD,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic [ILEN-1:0]               enq_instr,
  input  logic [XLEN-1:0]               enq_pc,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [ILEN-1:0]               deq_instr,
  output logic [XLEN-1:0]               deq_pc,
  output logic                          deq_compressed,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  ifq_occ_e         state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  ifq_entry_t enq_entry;
  ifq_entry_t head_entry;
  ifq_entry_t out_entry;
  logic       out_valid;
  logic       enq_fire;
  logic       deq_fire;
  logic       pass_through;
  logic       do_write;
  logic       do_read;

  assign enq_entry = ifq_capture(enq_instr, enq_pc);

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr_q),
    .wdata (enq_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

`ifdef IFQ_BYPASS_EN
  // An instruction offered to an empty queue is shown to decode immediately;
  // if decode takes it in the same cycle it never touches the storage.
  assign out_valid    = (state_q != OCC_EMPTY) || enq_valid;
  assign out_entry    = (state_q == OCC_EMPTY) ? enq_entry : head_entry;
  assign pass_through = (state_q == OCC_EMPTY) && enq_valid && deq_ready;
`else
  assign out_valid    = (state_q != OCC_EMPTY);
  assign out_entry    = head_entry;
  assign pass_through = 1'b0;
`endif

  // enq_ready comes from registered occupancy only, so no deq_ready -> enq_ready path exists.
  assign enq_fire = enq_valid && (state_q != OCC_FULL);
  assign deq_fire = out_valid && deq_ready;
  assign do_write = enq_fire && !pass_through;
  assign do_read  = deq_fire && !pass_through;

  // State register process
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      state_q  <= OCC_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Next-state process
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_read) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_write, do_read})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      OCC_EMPTY: begin
        if (do_write) begin
          state_d = OCC_PARTIAL;
        end
      end
      OCC_PARTIAL: begin
        if (do_write && !do_read && (count_q == CNT_W'(DEPTH-1))) begin
          state_d = OCC_FULL;
        end else if (do_read && !do_write && (count_q == CNT_W'(1))) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (do_read) begin
          state_d = OCC_PARTIAL;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
  end

  // Output process
  always_comb begin
    enq_ready      = (state_q != OCC_FULL);
    deq_valid      = out_valid;
    count          = count_q;
    deq_instr      = NOP;
    deq_pc         = '0;
    deq_compressed = 1'b0;
    if (out_valid) begin
      deq_instr      = out_entry.instr;
      deq_pc         = out_entry.pc;
      deq_compressed = out_entry.compressed;
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue: a queue model mirrors accepted instructions
// and every cycle the DUT outputs are compared against the model's head and occupancy.
module tb_fetch_instr_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [31:0] NOP_I = 32'h00000013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        compressed;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          FlushD;
  logic          enq_valid;
  logic          enq_ready;
  logic [31:0]   enq_instr;
  logic [63:0]   enq_pc;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   deq_instr;
  logic [63:0]   deq_pc;
  logic          deq_compressed;
  logic [CW-1:0] count;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  fetch_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .FlushD         (FlushD),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_instr      (enq_instr),
    .enq_pc         (enq_pc),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_instr      (deq_instr),
    .deq_pc         (deq_pc),
    .deq_compressed (deq_compressed),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_entry(input logic [31:0] instr, input logic [63:0] pc);
    exp_t e;
    e.pc         = pc;
    e.compressed = (instr[1:0] != 2'b11);
    e.instr      = e.compressed ? {16'h0000, instr[15:0]} : instr;
    return e;
  endfunction

  // Monitor: compare at the falling edge, then apply this cycle's handshakes to the model.
  int   m_sz;
  bit   m_vld;
  exp_t m_head;
  always @(negedge clk) begin
    if (mon_en) begin
      m_sz  = sb_q.size();
      m_vld = (m_sz > 0) || (BYPASS && enq_valid);
      check("count", 64'(count), 64'(m_sz));
      check("enq_ready", 64'(enq_ready), 64'(m_sz < DEPTH));
      check("deq_valid", 64'(deq_valid), 64'(m_vld));
      if (m_vld) begin
        m_head = (m_sz > 0) ? sb_q[0] : model_entry(enq_instr, enq_pc);
        check("deq_instr", 64'(deq_instr), 64'(m_head.instr));
        check("deq_pc", deq_pc, m_head.pc);
        check("deq_compressed", 64'(deq_compressed), 64'(m_head.compressed));
      end else begin
        check("idle_instr", 64'(deq_instr), 64'(NOP_I));
        check("idle_pc", deq_pc, 64'h0);
        check("idle_compressed", 64'(deq_compressed), 64'h0);
      end
      if (FlushD) begin
        $display("flush: dropped %0d entries", m_sz);
        sb_q.delete();
      end else begin
        if (enq_valid && (m_sz < DEPTH)) begin
          sb_q.push_back(model_entry(enq_instr, enq_pc));
        end
        if (deq_ready && m_vld) begin
          m_head = sb_q.pop_front();
          $display("deq pc=%h instr=%h c=%0d", m_head.pc, m_head.instr, m_head.compressed);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    FlushD    = 1'b0;
  endtask

  task automatic drain();
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      step();
    end
    check("drain_done", 64'(sb_q.size()), 64'h0);
    deq_ready = 1'b0;
    step();
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    enq_valid = 1'b1;
    enq_instr = instr;
    enq_pc    = pc;
    step();
  endtask

  initial begin
    reset     = 1'b1;
    FlushD    = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_instr = '0;
    enq_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    check("rst_count", 64'(count), 64'h0);
    check("rst_deq_valid", 64'(deq_valid), 64'h0);
    check("rst_enq_ready", 64'(enq_ready), 64'h1);
    check("rst_deq_instr", 64'(deq_instr), 64'(NOP_I));
    check("rst_deq_pc", deq_pc, 64'h0);
    check("rst_deq_c", 64'(deq_compressed), 64'h0);

    // 1: plain 32-bit instruction, visible one cycle after enqueue
    offer(32'h00000013, 64'h80000000);
    enq_valid = 1'b0;
    check("t1_valid", 64'(deq_valid), 64'h1);
    check("t1_pc", deq_pc, 64'h80000000);
    check("t1_c", 64'(deq_compressed), 64'h0);
    drain();

    // 2: compressed instructions, upper half cleared
    offer(32'h00004501, 64'h80000004);
    enq_valid = 1'b0;
    check("t2_instr", 64'(deq_instr), 64'h00004501);
    check("t2_c", 64'(deq_compressed), 64'h1);
    drain();
    offer(32'hABCD4501, 64'h80000008);
    enq_valid = 1'b0;
    check("t2_zeroed", 64'(deq_instr), 64'h00004501);
    drain();

    // 3: decode stalled, six offered, four accepted
    deq_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(32'h00100093 + 32'(i << 20), 64'h80001000 + 64'(4 * i));
    end
    enq_valid = 1'b0;
    check("t3_count", 64'(count), 64'h4);
    check("t3_enq_ready", 64'(enq_ready), 64'h0);
    check("t3_head_pc", deq_pc, 64'h80001000);
    drain();

    // 4: steady state at count=2 with simultaneous enq/deq, pointers wrap
    for (int i = 0; i < 2; i++) begin
      offer(32'h00200113 + 32'(i << 20), 64'h80002000 + 64'(4 * i));
    end
    deq_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      offer(32'h00200113 + 32'(i << 20), 64'h80002000 + 64'(4 * i));
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("t4_count", 64'(count), 64'h2);
    check("t4_head_pc", deq_pc, 64'h80002020);
    drain();

    // 5: flush with competing enq and deq
    for (int i = 0; i < 3; i++) begin
      offer(32'h00300193 + 32'(i << 20), 64'h80003000 + 64'(4 * i));
    end
    FlushD    = 1'b1;
    deq_ready = 1'b1;
    offer(32'h00300193, 64'h8000300C);
    idle_inputs();
    check("t5_count", 64'(count), 64'h0);
    check("t5_valid", 64'(deq_valid), 64'h0);
    check("t5_instr", 64'(deq_instr), 64'(NOP_I));
    check("t5_enq_ready", 64'(enq_ready), 64'h1);
    step();

    // 6: empty queue, enqueue and dequeue offered in the same cycle
    enq_valid = 1'b1;
    enq_instr = 32'h00000093;
    enq_pc    = 64'h80004000;
    deq_ready = 1'b1;
    #1;
    check("t6_same_cycle_valid", 64'(deq_valid), 64'(BYPASS));
    step();
    idle_inputs();
    check("t6_count", 64'(count), BYPASS ? 64'h0 : 64'h1);
    drain();

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      enq_valid = ($urandom_range(0, 3) != 0);
      deq_ready = ($urandom_range(0, 2) != 0);
      FlushD    = ($urandom_range(0, 31) == 0);
      enq_instr = $urandom();
      enq_pc    = {32'h00000000, $urandom()};
      step();
    end
    idle_inputs();
    drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
